// File: rtl/proc_debug_pkg.sv
// Shared debug-control types: run-mode encoding used by the
// step controller and by the debug display mux.
package proc_debug_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'd0,
    MODE_RUN   = 2'd1,
    MODE_BREAK = 2'd2
  } mode_e;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/step_controller_rate_counter.sv
// Run-rate prescaler: counts cycles while run is high, ticks when
// count reaches Peff-1 (Period=0 acts as 1), then restarts at 0.
// Ports: clk, rst, run, clear, period[DIV_WIDTH], tick.
module rate_counter #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] count_q;
  logic [DIV_WIDTH-1:0] last;

  assign last = (period == '0) ? '0
              : period - DIV_WIDTH'(1);

  // ">=" so a period shrunk below the current count
  // ticks at once instead of wrapping the counter.
  assign tick = run & (count_q >= last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (run) begin
      count_q <= tick ? '0
               : count_q + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/step_controller.sv
// Processor step/run/break controller issuing one-cycle clock
// enables. Ports: Clock, Reset, StepReq, RunReq, HaltReq,
// Period, BrkEnable, BrkAddr, PC -> ProcEnable, Mode,
// BreakHit, StepCount.
module step_controller
  import proc_debug_pkg::*;
#(
  parameter int PC_WIDTH  = 7,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 StepReq,
  input  logic                 RunReq,
  input  logic                 HaltReq,
  input  logic [DIV_WIDTH-1:0] Period,
  input  logic                 BrkEnable,
  input  logic [PC_WIDTH-1:0]  BrkAddr,
  input  logic [PC_WIDTH-1:0]  PC,
  output logic                 ProcEnable,
  output logic [1:0]           Mode,
  output logic                 BreakHit,
  output logic [15:0]          StepCount
);

  mode_e state_q;
  mode_e state_d;
  logic  en_d;
  logic  first_q;
  logic  first_d;
  logic  clear;
  logic  tick;
  logic  brk_match;

  rate_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_rate (
    .clk   (Clock),
    .rst   (Reset),
    .run   (state_q == MODE_RUN),
    .clear (clear),
    .period(Period),
    .tick  (tick)
  );

  // The first tick after entering RUN is exempt so a run
  // can leave a PC parked on the breakpoint.
  assign brk_match = BrkEnable & (PC == BrkAddr) & ~first_q;

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    first_d = first_q;
    clear   = 1'b0;
    case (state_q)
      MODE_HALT, MODE_BREAK: begin
        if (HaltReq) begin
          state_d = MODE_HALT;
        end else if (StepReq) begin
          state_d = MODE_HALT;
          en_d    = 1'b1;
        end else if (RunReq) begin
          state_d = MODE_RUN;
          clear   = 1'b1;
          first_d = 1'b1;
        end
      end
      MODE_RUN: begin
        if (HaltReq) begin
          state_d = MODE_HALT;
        end else if (tick) begin
          if (brk_match) begin
            state_d = MODE_BREAK;
          end else begin
            en_d    = 1'b1;
            first_d = 1'b0;
          end
        end
      end
      default: state_d = MODE_HALT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= MODE_HALT;
      ProcEnable <= 1'b0;
      first_q    <= 1'b0;
      StepCount  <= '0;
    end else begin
      state_q    <= state_d;
      ProcEnable <= en_d;
      first_q    <= first_d;
      StepCount  <= StepCount + {15'd0, ProcEnable};
    end
  end

  assign Mode     = state_q;
  assign BreakHit = (state_q == MODE_BREAK);

endmodule
